// File: rtl/my_8to3_request_encoder_if.sv
// rtl/my_8to3_request_encoder_if.sv - encoded request output handshake
//
// Carries one 3-bit code from the encoder to its consumer.
//   out_code  : binary index of the presented request   (master -> slave)
//   out_valid : out_code holds a valid request           (master -> slave)
//   out_ready : consumer accepts on valid && ready edge  (slave -> master)
interface my_8to3_request_encoder_if;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_code,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_code,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/my_8to3_request_encoder.sv
// rtl/my_8to3_request_encoder.sv - collects request strobes and emits one 3-bit code per event
//
// Ports:
//   clock        : system clock, all state updates on the rising edge
//   reset        : synchronous, active-high reset
//   enable       : when low, req_bits are ignored; pending/output logic keeps running
//   req_bits     : request strobes, bit i requests code i, any number per cycle
//   clear_all    : synchronous flush of the pending set and the output stage
//   out_bus      : code/valid/ready handshake toward the control stage
//   pending_bits : pending register, excluding the code held in the output stage
//   overflow     : one-cycle pulse when a request hits an already-pending bit
//
// ROUND_ROBIN = 0 selects the highest pending index; ROUND_ROBIN = 1 scans
// upward starting just after the last issued code.
module my_8to3_request_encoder #(
    parameter int ROUND_ROBIN = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [7:0]                        req_bits,
    input  logic                              clear_all,
    my_8to3_request_encoder_if.master         out_bus,
    output logic [7:0]                        pending_bits,
    output logic                              overflow
);

    logic [7:0] pending_q;
    logic [2:0] out_code_q;
    logic       out_valid_q;
    logic       overflow_q;
    logic [2:0] rr_ptr_q;

    logic       load;
    logic [2:0] sel;
    logic [2:0] sel_fixed;
    logic [2:0] sel_rr;
    logic [2:0] rr_idx;
    logic [7:0] load_mask;
    logic [7:0] req_gated;

    // The output stage can take a new code when it is empty or being drained.
    assign load = (!out_valid_q || out_bus.out_ready) && (pending_q != 8'h00);

    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin
        sel_fixed = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                sel_fixed = 3'(i);
            end
        end
    end

    // Round robin: scan offsets 8 down to 1 so the smallest offset from
    // rr_ptr that hits a pending bit is the last write and wins. Offset 8
    // wraps to rr_ptr itself, which is checked last in priority.
    always_comb begin
        sel_rr = 3'd0;
        rr_idx = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            rr_idx = rr_ptr_q + 3'(k);
            if (pending_q[rr_idx]) begin
                sel_rr = rr_idx;
            end
        end
    end

    assign sel       = (ROUND_ROBIN != 0) ? sel_rr : sel_fixed;
    assign load_mask = load ? (8'b0000_0001 << sel) : 8'h00;
    assign req_gated = enable ? req_bits : 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q   <= 8'h00;
            out_code_q  <= 3'd0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            rr_ptr_q    <= 3'd7;
        end else if (clear_all) begin
            // Flush drops same-cycle requests; pointer and last code are kept.
            pending_q   <= 8'h00;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            // The transferred bit is cleared first, so a same-cycle request
            // for it is kept as a fresh event rather than merged.
            pending_q  <= (pending_q & ~load_mask) | req_gated;
            overflow_q <= |(req_gated & pending_q & ~load_mask);
            if (load) begin
                out_code_q  <= sel;
                out_valid_q <= 1'b1;
                rr_ptr_q    <= sel;
            end else if (out_bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_bus.out_code  = out_code_q;
    assign out_bus.out_valid = out_valid_q;
    assign pending_bits      = pending_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_my_8to3_request_encoder.sv
// tb/tb_my_8to3_request_encoder.sv - self-checking bench for my_8to3_request_encoder
module tb_my_8to3_request_encoder;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] req_bits;
    logic       clear_all;
    logic       out_ready;

    logic [7:0] pend_fp;
    logic [7:0] pend_rr;
    logic       ovf_fp;
    logic       ovf_rr;

    my_8to3_request_encoder_if bus_fp ();
    my_8to3_request_encoder_if bus_rr ();

    assign bus_fp.out_ready = out_ready;
    assign bus_rr.out_ready = out_ready;

    my_8to3_request_encoder #(.ROUND_ROBIN(0)) dut_fp (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .req_bits     (req_bits),
        .clear_all    (clear_all),
        .out_bus      (bus_fp.master),
        .pending_bits (pend_fp),
        .overflow     (ovf_fp)
    );

    my_8to3_request_encoder #(.ROUND_ROBIN(1)) dut_rr (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .req_bits     (req_bits),
        .clear_all    (clear_all),
        .out_bus      (bus_rr.master),
        .pending_bits (pend_rr),
        .overflow     (ovf_rr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [2:0] q_fp[$];
    logic [2:0] q_rr[$];
    bit         sb_fp;
    bit         sb_rr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard pop: runs with inputs already set, so valid && ready here
    // means the accept happens at the coming edge.
    task automatic monitor();
        logic [2:0] e;
        if (sb_fp && bus_fp.out_valid && out_ready) begin
            if (q_fp.size() == 0) chk("fp_unexpected_code", {5'd0, bus_fp.out_code}, 8'hEE);
            else begin
                e = q_fp.pop_front();
                chk("fp_code", {5'd0, bus_fp.out_code}, {5'd0, e});
            end
        end
        if (sb_rr && bus_rr.out_valid && out_ready) begin
            if (q_rr.size() == 0) chk("rr_unexpected_code", {5'd0, bus_rr.out_code}, 8'hEE);
            else begin
                e = q_rr.pop_front();
                chk("rr_code", {5'd0, bus_rr.out_code}, {5'd0, e});
            end
        end
    endtask

    task automatic tick();
        monitor();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_bits  = 8'h00;
        clear_all = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        req_bits  = 8'hA5;
        clear_all = 1'b0;
        out_ready = 1'b1;
        sb_fp     = 1'b1;
        sb_rr     = 1'b0;
        @(negedge clock);
        tick();
        tick();

        // Reset state, req_bits during reset discarded
        chk("rst_valid",   {7'd0, bus_fp.out_valid}, 8'h00);
        chk("rst_code",    {5'd0, bus_fp.out_code},  8'h00);
        chk("rst_pending", pend_fp,                  8'h00);
        chk("rst_ovf",     {7'd0, ovf_fp},           8'h00);
        do_reset();

        // Fixed priority: 0x24 -> 5 then 2
        out_ready = 1'b1;
        req_bits  = 8'h24;
        q_fp.push_back(3'd5);
        q_fp.push_back(3'd2);
        tick();
        chk("fp_pend_cap", pend_fp, 8'h24);
        req_bits = 8'h00;
        tick();
        chk("fp_valid5", {7'd0, bus_fp.out_valid}, 8'h01);
        tick();
        chk("fp_pend_empty", pend_fp, 8'h00);
        tick();
        chk("fp_valid_fall", {7'd0, bus_fp.out_valid}, 8'h00);
        chk("fp_q_drained", 8'(q_fp.size()), 8'h00);

        // Backpressure: 0x81, code 7 held for 10 cycles
        do_reset();
        out_ready = 1'b0;
        req_bits  = 8'h81;
        q_fp.push_back(3'd7);
        q_fp.push_back(3'd0);
        tick();
        req_bits = 8'h00;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_code_hold",  {5'd0, bus_fp.out_code},  8'h07);
            chk("bp_valid_hold", {7'd0, bus_fp.out_valid}, 8'h01);
            chk("bp_pend_hold",  pend_fp,                  8'h01);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_code0", {5'd0, bus_fp.out_code},  8'h00);
        chk("bp_valid0", {7'd0, bus_fp.out_valid}, 8'h01);
        tick();
        chk("bp_valid_fall", {7'd0, bus_fp.out_valid}, 8'h00);

        // Gating: enable low ignores requests
        enable   = 1'b0;
        req_bits = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gate_valid", {7'd0, bus_fp.out_valid}, 8'h00);
            chk("gate_pend",  pend_fp,                  8'h00);
        end
        req_bits = 8'h00;
        enable   = 1'b1;

        // Overflow: duplicate of a still-pending bit
        do_reset();
        out_ready = 1'b0;
        req_bits  = 8'h03;
        q_fp.push_back(3'd1);
        q_fp.push_back(3'd0);
        tick();
        req_bits = 8'h00;
        tick();
        chk("ov_code1", {5'd0, bus_fp.out_code}, 8'h01);
        chk("ov_pend1", pend_fp,                 8'h01);
        chk("ov_quiet", {7'd0, ovf_fp},          8'h00);
        req_bits = 8'h01;
        tick();
        chk("ov_pulse",     {7'd0, ovf_fp}, 8'h01);
        chk("ov_pend_same", pend_fp,        8'h01);
        req_bits = 8'h00;
        tick();
        chk("ov_pulse_end", {7'd0, ovf_fp}, 8'h00);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("ov_q_drained", 8'(q_fp.size()), 8'h00);

        // Round robin vs fixed on 0xFF then 0x11
        do_reset();
        sb_rr     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q_rr.push_back(3'(i));
            q_fp.push_back(3'(7 - i));
        end
        req_bits = 8'hFF;
        tick();
        req_bits = 8'h00;
        for (int i = 0; i < 10; i++) tick();
        chk("rr_q_drained1", 8'(q_rr.size()), 8'h00);
        chk("fp_q_drained1", 8'(q_fp.size()), 8'h00);
        q_rr.push_back(3'd0);
        q_rr.push_back(3'd4);
        q_fp.push_back(3'd4);
        q_fp.push_back(3'd0);
        req_bits = 8'h11;
        tick();
        req_bits = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        chk("rr_q_drained2", 8'(q_rr.size()), 8'h00);
        chk("fp_q_drained2", 8'(q_fp.size()), 8'h00);
        chk("rr_valid_fall", {7'd0, bus_rr.out_valid}, 8'h00);
        sb_rr = 1'b0;

        // Flush with same-cycle request
        do_reset();
        out_ready = 1'b0;
        req_bits  = 8'hF0;
        tick();
        req_bits = 8'h00;
        tick();
        chk("fl_code7", {5'd0, bus_fp.out_code}, 8'h07);
        chk("fl_pend",  pend_fp,                 8'h70);
        clear_all = 1'b1;
        req_bits  = 8'h01;
        tick();
        clear_all = 1'b0;
        req_bits  = 8'h00;
        chk("fl_valid", {7'd0, bus_fp.out_valid}, 8'h00);
        chk("fl_pend0", pend_fp,                  8'h00);
        chk("fl_ovf",   {7'd0, ovf_fp},           8'h00);
        tick();
        chk("fl_stay_empty", pend_fp, 8'h00);

        // Reset mid-operation
        do_reset();
        out_ready = 1'b0;
        req_bits  = 8'hF0;
        tick();
        req_bits = 8'h00;
        tick();
        chk("mr_valid_pre", {7'd0, bus_fp.out_valid}, 8'h01);
        reset    = 1'b1;
        req_bits = 8'h01;
        tick();
        reset    = 1'b0;
        req_bits = 8'h00;
        chk("mr_valid", {7'd0, bus_fp.out_valid}, 8'h00);
        chk("mr_code",  {5'd0, bus_fp.out_code},  8'h00);
        chk("mr_pend",  pend_fp,                  8'h00);
        chk("mr_ovf",   {7'd0, ovf_fp},           8'h00);
        tick();
        chk("mr_pend_after", pend_fp, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
